// File: rtl/jump_target_encoder.sv
// Packs a 32-bit byte jump target into a J/JAL instruction word and exposes its rs/rt/imediato-shaped fields.
// Region check against pc[31:28] is compiled in only when JUMP_ENC_REGION_CHECK_EN is defined.
module jump_target_encoder #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             link,
   input  logic [31:0]      target,
   input  logic [31:0]      pc,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      instr_out,
   output logic [4:0]       rs_out,
   output logic [4:0]       rt_out,
   output logic [15:0]      imediato_out,
   output logic             err_align,
   output logic             err_region,
   output logic [CNT_W-1:0] encode_count
);

   typedef enum logic [1:0] {IDLE, CHECK, PACK, HOLD} state_t;

   state_t             state_q, state_d;
   logic [31:0]        tgt_q, tgt_d;
   logic               link_q, link_d;
   logic               err_align_q, err_align_d;
   logic               err_region_q, err_region_d;
   logic [31:0]        instr_q, instr_d;
   logic [4:0]         rs_q, rs_d;
   logic [4:0]         rt_q, rt_d;
   logic [15:0]        imm_q, imm_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef JUMP_ENC_REGION_CHECK_EN
   logic [3:0]         pc_hi_q, pc_hi_d;
   logic               unused_ok;
   assign unused_ok = ^pc[27:0];
`else
   // Without the region check the PC and the target's region bits have no effect.
   logic               unused_ok;
   assign unused_ok = ^{pc, tgt_q[31:28]};
`endif

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      link_d       = link_q;
      err_align_d  = err_align_q;
      err_region_d = err_region_q;
      instr_d      = instr_q;
      rs_d         = rs_q;
      rt_d         = rt_q;
      imm_d        = imm_q;
      out_valid_d  = out_valid_q;
      cnt_d        = cnt_q;
`ifdef JUMP_ENC_REGION_CHECK_EN
      pc_hi_d      = pc_hi_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               tgt_d        = target;
               link_d       = link;
`ifdef JUMP_ENC_REGION_CHECK_EN
               pc_hi_d      = pc[31:28];
`endif
               err_align_d  = 1'b0;
               err_region_d = 1'b0;
               instr_d      = '0;
               rs_d         = '0;
               rt_d         = '0;
               imm_d        = '0;
               state_d      = CHECK;
            end
         end
         CHECK: begin
            err_align_d  = |tgt_q[1:0];
`ifdef JUMP_ENC_REGION_CHECK_EN
            err_region_d = (tgt_q[31:28] != pc_hi_q);
`else
            err_region_d = 1'b0;
`endif
            state_d      = PACK;
         end
         PACK: begin
            if (!err_align_q && !err_region_q) begin
               instr_d = {(link_q ? 6'h03 : 6'h02), tgt_q[27:2]};
               rs_d    = tgt_q[27:23];
               rt_d    = tgt_q[22:18];
               imm_d   = tgt_q[17:2];
            end else begin
               instr_d = '0;
               rs_d    = '0;
               rt_d    = '0;
               imm_d   = '0;
            end
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
               if (!err_align_q && !err_region_q)
                  cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         tgt_q        <= '0;
         link_q       <= 1'b0;
         err_align_q  <= 1'b0;
         err_region_q <= 1'b0;
         instr_q      <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         imm_q        <= '0;
         out_valid_q  <= 1'b0;
         cnt_q        <= '0;
`ifdef JUMP_ENC_REGION_CHECK_EN
         pc_hi_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         link_q       <= link_d;
         err_align_q  <= err_align_d;
         err_region_q <= err_region_d;
         instr_q      <= instr_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         imm_q        <= imm_d;
         out_valid_q  <= out_valid_d;
         cnt_q        <= cnt_d;
`ifdef JUMP_ENC_REGION_CHECK_EN
         pc_hi_q      <= pc_hi_d;
`endif
      end
   end

   assign busy         = (state_q != IDLE);
   assign out_valid    = out_valid_q;
   assign instr_out    = instr_q;
   assign rs_out       = rs_q;
   assign rt_out       = rt_q;
   assign imediato_out = imm_q;
   assign err_align    = err_align_q;
   assign err_region   = err_region_q;
   assign encode_count = cnt_q;

endmodule

// File: tb/tb_jump_target_encoder.sv
// Directed self-checking bench for jump_target_encoder; inputs driven and outputs sampled on the falling edge.
module tb_jump_target_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        link;
   logic [31:0] target;
   logic [31:0] pc;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr_out;
   logic [4:0]  rs_out;
   logic [4:0]  rt_out;
   logic [15:0] imediato_out;
   logic        err_align;
   logic        err_region;
   logic [7:0]  encode_count;

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;
   logic [7:0]  exp_cnt;

   always #5 clk = ~clk;

   jump_target_encoder #(.CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .link         (link),
      .target       (target),
      .pc           (pc),
      .busy         (busy),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .instr_out    (instr_out),
      .rs_out       (rs_out),
      .rt_out       (rt_out),
      .imediato_out (imediato_out),
      .err_align    (err_align),
      .err_region   (err_region),
      .encode_count (encode_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   // Called on a falling edge; returns on the falling edge after the capture edge with inputs scrambled.
   task automatic req(input logic l, input logic [31:0] t, input logic [31:0] p);
      start  = 1'b1;
      link   = l;
      target = t;
      pc     = p;
      @(negedge clk);
      start  = 1'b0;
      link   = ~l;
      target = 32'hDEAD_BEEF;
      pc     = 32'hFFFF_FFFF;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      link      = 1'b0;
      target    = '0;
      pc        = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy",  busy,         0);
      chk("rst_valid", out_valid,    0);
      chk("rst_instr", instr_out,    0);
      chk("rst_count", encode_count, 0);
      chk("rst_erra",  err_align,    0);
      reset   = 1'b0;
      exp_cnt = 8'd0;
      @(negedge clk);

      // J within region
      req(1'b0, 32'h0040_0100, 32'h0040_0000);
      chk("t1_busy_e0",  busy,      1);
      chk("t1_valid_e0", out_valid, 0);
      @(negedge clk);
      chk("t1_erra_e1",  err_align,  0);
      chk("t1_errr_e1",  err_region, 0);
      chk("t1_valid_e1", out_valid,  0);
      @(negedge clk);
      chk("t1_valid", out_valid,    1);
      chk("t1_instr", instr_out,    32'h0810_0040);
      chk("t1_rs",    rs_out,       0);
      chk("t1_rt",    rt_out,       32'h10);
      chk("t1_imm",   imediato_out, 32'h0040);
      chk("t1_cnt0",  encode_count, 0);
      handshake();
      exp_cnt = 8'd1;
      chk("t1_cnt1",   encode_count, exp_cnt);
      chk("t1_valid0", out_valid,    0);
      chk("t1_busy0",  busy,         0);

      // JAL with all field bits set
      req(1'b1, 32'h0FFF_FFFC, 32'h0000_0000);
      repeat (2) @(negedge clk);
      chk("t2_instr", instr_out,    32'h0FFF_FFFF);
      chk("t2_rs",    rs_out,       31);
      chk("t2_rt",    rt_out,       31);
      chk("t2_imm",   imediato_out, 32'hFFFF);
      handshake();
      exp_cnt = 8'd2;
      chk("t2_cnt", encode_count, exp_cnt);

      // Misaligned target
      req(1'b0, 32'h0040_0102, 32'h0040_0000);
      @(negedge clk);
      chk("t3_erra_e1",  err_align, 1);
      chk("t3_valid_e1", out_valid, 0);
      @(negedge clk);
      chk("t3_valid", out_valid,    1);
      chk("t3_instr", instr_out,    0);
      chk("t3_rs",    rs_out,       0);
      chk("t3_rt",    rt_out,       0);
      chk("t3_imm",   imediato_out, 0);
      handshake();
      chk("t3_cnt",       encode_count, exp_cnt);
      chk("t3_erra_kept", err_align,    1);

      // Out-of-region target
      req(1'b0, 32'h0040_0000, 32'h1000_0000);
      chk("t4_erra_clr", err_align, 0);
      repeat (2) @(negedge clk);
`ifdef JUMP_ENC_REGION_CHECK_EN
      chk("t4_errr",  err_region, 1);
      chk("t4_instr", instr_out,  0);
`else
      chk("t4_errr",  err_region, 0);
      chk("t4_instr", instr_out,  32'h0810_0000);
      exp_cnt = exp_cnt + 8'd1;
`endif
      handshake();
      chk("t4_cnt", encode_count, exp_cnt);

      // Back-pressure in HOLD with start pulses
      req(1'b0, 32'h0040_0100, 32'h0040_0000);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         start  = (i % 2 == 0);
         link   = 1'b1;
         target = 32'h0FFF_FFFC;
         pc     = 32'h0000_0000;
         @(negedge clk);
         chk("t5_valid_hold", out_valid, 1);
         chk("t5_busy_hold",  busy,      1);
         chk("t5_instr_hold", instr_out, 32'h0810_0040);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      exp_cnt   = exp_cnt + 8'd1;
      chk("t5_busy_hs",  busy,         0);
      chk("t5_valid_hs", out_valid,    0);
      chk("t5_cnt",      encode_count, exp_cnt);
      chk("t5_instr_hs", instr_out,    32'h0810_0040);
      @(negedge clk);
      chk("t5_no_capture", busy, 0);

      // Reset while in PACK
      req(1'b0, 32'h0040_0100, 32'h0040_0000);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t6_busy",  busy,         0);
      chk("t6_valid", out_valid,    0);
      chk("t6_instr", instr_out,    0);
      chk("t6_rs",    rs_out,       0);
      chk("t6_rt",    rt_out,       0);
      chk("t6_imm",   imediato_out, 0);
      chk("t6_erra",  err_align,    0);
      chk("t6_cnt",   encode_count, 0);
      exp_cnt = 8'd0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      req(1'b1, 32'h0FFF_FFFC, 32'h0000_0000);
      repeat (2) @(negedge clk);
      chk("t6_post_instr", instr_out, 32'h0FFF_FFFF);
      handshake();
      exp_cnt = exp_cnt + 8'd1;
      chk("t6_post_cnt", encode_count, exp_cnt);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
